ex_result_buffer: RTL and testbench



---
 rtl/ex_result_buffer.sv | 133 +++++++++++++
 tb/tb_ex_result_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_result_buffer.sv
// Execute-stage result buffer: FU arbitration, circular FIFO, registered ex_reg.
// Define EXBUF_BYPASS_EN to let an empty FIFO forward straight to ex_reg.
package ex_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  Tag;
    logic        take_branch;
    logic [31:0] NPC;
    logic [31:0] alu_result;
  } EX_PACKET;
endpackage

module ex_result_buffer
  import ex_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NUM_FU = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  input  EX_PACKET               fu_packet [NUM_FU],
  output logic [NUM_FU-1:0]      fu_ready,
  output EX_PACKET               ex_reg,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (NUM_FU > 2) ? 2 : 1;
`ifdef EXBUF_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  EX_PACKET      mem_q [DEPTH];
  EX_PACKET      mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rr_q, rr_d;
  EX_PACKET      ex_reg_q, ex_reg_d;

  // Position of a port in the cyclic order that starts at rr.
  function automatic int slot_off(input int port, input int rr);
    return (port - rr + NUM_FU) % NUM_FU;
  endfunction

  // The head slot frees up this cycle when anything is queued.
  always_comb begin : ready_logic
    int free;
    free = DEPTH - int'(count_q) + ((count_q != '0) ? 1 : 0);
    fu_ready = '0;
    for (int j = 0; j < NUM_FU; j++)
      fu_ready[j] = (slot_off(j, int'(rr_q)) < free);
    if (!reset || squash)
      fu_ready = '0;
  end

  always_comb begin : queue_logic
    int   n_enq;
    logic byp_done;
    logic is_byp;
    logic denied;
    mem_d    = mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    rr_d     = rr_q;
    ex_reg_d = '0;
    n_enq    = 0;
    byp_done = 1'b0;
    is_byp   = 1'b0;
    denied   = 1'b0;
    if (count_q != '0) begin
      ex_reg_d = mem_q[head_q];
      head_d   = head_q + AW'(1);
    end
    for (int k = 0; k < NUM_FU; k++) begin
      for (int j = 0; j < NUM_FU; j++) begin
        if (slot_off(j, int'(rr_q)) == k && fu_packet[j].valid) begin
          if (fu_ready[j]) begin
            is_byp = BYP_EN && (count_q == '0) && !byp_done;
            if (is_byp) begin
              ex_reg_d = fu_packet[j];
              byp_done = 1'b1;
            end else begin
              mem_d[tail_q + AW'(n_enq)] = fu_packet[j];
              n_enq = n_enq + 1;
            end
          end else if (!denied) begin
            rr_d   = PW'(j);
            denied = 1'b1;
          end
        end
      end
    end
    tail_d  = tail_q + AW'(n_enq);
    count_d = CW'(int'(count_q) - ((count_q != '0) ? 1 : 0) + n_enq);
    if (squash) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      rr_d     = '0;
      ex_reg_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rr_q     <= '0;
      ex_reg_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
      ex_reg_q <= ex_reg_d;
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign ex_reg    = ex_reg_q;
  assign occupancy = count_q;

endmodule

// File: tb/tb_ex_result_buffer.sv
// Testbench for ex_result_buffer (DEPTH=4, NUM_FU=2) with a queue-based model.
// Follows EXBUF_BYPASS_EN for the expected latency.
module tb_ex_result_buffer;
  import ex_pkg::*;

  localparam int DEPTH = 4;
  localparam int N     = 2;
`ifdef EXBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       squash = 1'b0;
  EX_PACKET   fu_packet [N];
  logic [1:0] fu_ready;
  EX_PACKET   ex_reg;
  logic [2:0] occupancy;

  always #5 clock = ~clock;

  ex_result_buffer #(.DEPTH(DEPTH), .NUM_FU(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .fu_packet (fu_packet),
    .fu_ready  (fu_ready),
    .ex_reg    (ex_reg),
    .occupancy (occupancy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  EX_PACKET   mq[$];
  int         rr_m = 0;
  logic [1:0] exp_rdy, act_rdy;
  EX_PACKET   exp_out, act_out;
  int         exp_occ;
  logic [2:0] act_occ;

  function automatic EX_PACKET mk(input int tag, input bit v);
    EX_PACKET p;
    p.valid       = v;
    p.Tag         = 6'(tag);
    p.take_branch = 1'($urandom);
    p.NPC         = $urandom;
    p.alu_result  = $urandom;
    return p;
  endfunction

  function automatic logic [1:0] model_ready();
    logic [1:0] r;
    int f;
    r = '0;
    f = DEPTH - mq.size() + ((mq.size() > 0) ? 1 : 0);
    for (int k = 0; k < N; k++)
      if (k < f) r[1'((rr_m + k) % N)] = 1'b1;
    return r;
  endfunction

  // Drive one cycle, advance the model, sample the DUT after the edge.
  task automatic step(input EX_PACKET a, input EX_PACKET b, input bit sq);
    EX_PACKET acc[$];
    EX_PACKET pk[2];
    int nrr;
    bit den;
    fu_packet[0] = a;
    fu_packet[1] = b;
    squash = sq;
    #1;
    exp_rdy = sq ? 2'b00 : model_ready();
    act_rdy = fu_ready;
    pk[0] = a;
    pk[1] = b;
    nrr = rr_m;
    den = 1'b0;
    if (sq) begin
      mq.delete();
      rr_m = 0;
      exp_out = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr_m + k) % N;
        if (pk[j].valid) begin
          if (exp_rdy[1'(j)]) acc.push_back(pk[j]);
          else if (!den) begin nrr = j; den = 1'b1; end
        end
      end
      if (mq.size() > 0) exp_out = mq.pop_front();
      else if (BYP && acc.size() > 0) exp_out = acc.pop_front();
      else exp_out = '0;
      foreach (acc[i]) mq.push_back(acc[i]);
      rr_m = nrr;
    end
    exp_occ = mq.size();
    @(posedge clock);
    #1;
    act_out = ex_reg;
    act_occ = occupancy;
    @(negedge clock);
    fu_packet[0] = '0;
    fu_packet[1] = '0;
    squash = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    fu_packet[0] = '0;
    fu_packet[1] = '0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_tests += 3;
    if (ex_reg !== '0) begin n_fail++; $display("FAIL rst_init ex_reg act=%h exp=0", ex_reg); end
    if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_init occ act=%0d exp=0", occupancy); end
    if (fu_ready !== 2'b00) begin n_fail++; $display("FAIL rst_init rdy act=%b exp=00", fu_ready); end
    reset = 1'b1;
    mq.delete();
    rr_m = 0;
    for (int i = 0; i < (BYP ? 4 : 3); i++) begin
      if (i == 0) step('0, '0, 1'b0);
      else step(mk(40 + 2 * i, 1), mk(41 + 2 * i, 1), 1'b0);
      n_tests += 3;
      if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL rst_fill rdy c%0d act=%b exp=%b", i, act_rdy, exp_rdy); end
      if (act_out !== exp_out) begin n_fail++; $display("FAIL rst_fill out c%0d act=%h exp=%h", i, act_out, exp_out); end
      if (act_occ !== 3'(exp_occ)) begin n_fail++; $display("FAIL rst_fill occ c%0d act=%0d exp=%0d", i, act_occ, exp_occ); end
    end
    n_tests++;
    if (act_occ !== 3'd3) begin n_fail++; $display("FAIL rst_fill queued act=%0d exp=3", act_occ); end
    #2 reset = 1'b0;
    #1;
    n_tests += 3;
    if (ex_reg.valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid valid act=%b exp=0", ex_reg.valid); end
    if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_mid occ act=%0d exp=0", occupancy); end
    if (fu_ready !== 2'b00) begin n_fail++; $display("FAIL rst_mid rdy act=%b exp=00", fu_ready); end
    mq.delete();
    rr_m = 0;
    @(negedge clock);
    n_tests++;
    if (fu_ready !== 2'b00) begin n_fail++; $display("FAIL rst_hold rdy act=%b exp=00", fu_ready); end
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step('0, '0, 1'b0);
      if (act_out.valid === 1'b1) seen++;
      n_tests += 2;
      if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL rst_after rdy c%0d act=%b exp=%b", i, act_rdy, exp_rdy); end
      if (act_occ !== 3'(exp_occ)) begin n_fail++; $display("FAIL rst_after occ c%0d act=%0d exp=%0d", i, act_occ, exp_occ); end
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_dropped emitted act=%0d exp=0", seen); end
  endtask

  task automatic test_single();
    EX_PACKET p;
    int first;
    int nvalid;
    p = mk(5, 1);
    p.alu_result = 32'h1234;
    first = -1;
    nvalid = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(p, '0, 1'b0);
      else step('0, '0, 1'b0);
      if (act_out.valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = i;
        n_tests++;
        if (act_out !== p) begin n_fail++; $display("FAIL single pkt act=%h exp=%h", act_out, p); end
      end
      n_tests += 2;
      if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL single rdy c%0d act=%b exp=%b", i, act_rdy, exp_rdy); end
      if (act_out !== exp_out) begin n_fail++; $display("FAIL single out c%0d act=%h exp=%h", i, act_out, exp_out); end
    end
    n_tests += 2;
    if (first != (BYP ? 0 : 1)) begin n_fail++; $display("FAIL single latency act=%0d exp=%0d", first + 1, BYP ? 1 : 2); end
    if (nvalid != 1) begin n_fail++; $display("FAIL single valid_cycles act=%0d exp=1", nvalid); end
  endtask

  task automatic test_dual();
    int tags[$];
    int pos[$];
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(mk(1, 1), mk(2, 1), 1'b0);
      else step('0, '0, 1'b0);
      if (act_out.valid === 1'b1) begin
        tags.push_back(int'(act_out.Tag));
        pos.push_back(i);
      end
      n_tests += 2;
      if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL dual rdy c%0d act=%b exp=%b", i, act_rdy, exp_rdy); end
      if (act_out !== exp_out) begin n_fail++; $display("FAIL dual out c%0d act=%h exp=%h", i, act_out, exp_out); end
    end
    n_tests++;
    if (tags.size() != 2 || tags[0] != 1 || tags[1] != 2 || pos[1] != pos[0] + 1) begin
      n_fail++;
      $display("FAIL dual order act_count=%0d exp 2 consecutive tags 1,2", tags.size());
    end
  endtask

  task automatic test_saturation();
    int g0, g1, max_occ, occ_before, nout;
    logic [1:0] prev;
    bit prev_sat;
    bit seen_tag [64];
    bit dup;
    g0 = 0; g1 = 0; max_occ = 0; nout = 0;
    prev = '0; prev_sat = 1'b0; dup = 1'b0;
    foreach (seen_tag[i]) seen_tag[i] = 1'b0;
    for (int i = 0; i < 26; i++) begin
      occ_before = mq.size();
      if (i < 20) step(mk(2 * i, 1), mk(2 * i + 1, 1), 1'b0);
      else step('0, '0, 1'b0);
      if (i < 20) begin
        g0 += int'(act_rdy[0]);
        g1 += int'(act_rdy[1]);
      end
      if (int'(act_occ) > max_occ) max_occ = int'(act_occ);
      if (act_out.valid === 1'b1) begin
        nout++;
        if (seen_tag[act_out.Tag]) dup = 1'b1;
        seen_tag[act_out.Tag] = 1'b1;
      end
      if (i < 20 && occ_before == DEPTH) begin
        n_tests++;
        if (!$onehot(act_rdy)) begin n_fail++; $display("FAIL sat onehot c%0d act=%b", i, act_rdy); end
        if (prev_sat) begin
          n_tests++;
          if (act_rdy === prev) begin n_fail++; $display("FAIL sat alternate c%0d act=%b prev=%b", i, act_rdy, prev); end
        end
        prev_sat = 1'b1;
      end
      prev = act_rdy;
      n_tests += 3;
      if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL sat rdy c%0d act=%b exp=%b", i, act_rdy, exp_rdy); end
      if (act_out !== exp_out) begin n_fail++; $display("FAIL sat out c%0d act=%h exp=%h", i, act_out, exp_out); end
      if (act_occ !== 3'(exp_occ)) begin n_fail++; $display("FAIL sat occ c%0d act=%0d exp=%0d", i, act_occ, exp_occ); end
    end
    n_tests += 4;
    if (max_occ != DEPTH) begin n_fail++; $display("FAIL sat max_occ act=%0d exp=%0d", max_occ, DEPTH); end
    if (g0 - g1 > 1 || g1 - g0 > 1) begin n_fail++; $display("FAIL sat fairness g0=%0d g1=%0d exp diff<=1", g0, g1); end
    if (dup) begin n_fail++; $display("FAIL sat duplicate act=1 exp=0"); end
    if (nout != g0 + g1) begin n_fail++; $display("FAIL sat emitted act=%0d exp=%0d", nout, g0 + g1); end
  endtask

  task automatic test_squash();
    int leaked;
    leaked = 0;
    for (int i = 0; i < (BYP ? 3 : 2); i++) begin
      step(mk(20 + 2 * i, 1), mk(21 + 2 * i, 1), 1'b0);
      n_tests++;
      if (act_out !== exp_out) begin n_fail++; $display("FAIL sq_fill out c%0d act=%h exp=%h", i, act_out, exp_out); end
    end
    n_tests++;
    if (act_occ !== 3'd3) begin n_fail++; $display("FAIL sq_fill queued act=%0d exp=3", act_occ); end
    step('0, mk(50, 1), 1'b1);
    n_tests += 3;
    if (act_rdy !== 2'b00) begin n_fail++; $display("FAIL sq rdy act=%b exp=00", act_rdy); end
    if (act_out.valid !== 1'b0) begin n_fail++; $display("FAIL sq valid act=%b exp=0", act_out.valid); end
    if (act_occ !== 3'd0) begin n_fail++; $display("FAIL sq occ act=%0d exp=0", act_occ); end
    for (int i = 0; i < 4; i++) begin
      step('0, '0, 1'b0);
      if (act_out.valid === 1'b1) leaked++;
      n_tests += 2;
      if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL sq_after rdy c%0d act=%b exp=%b", i, act_rdy, exp_rdy); end
      if (act_out !== exp_out) begin n_fail++; $display("FAIL sq_after out c%0d act=%h exp=%h", i, act_out, exp_out); end
    end
    n_tests++;
    if (leaked != 0) begin n_fail++; $display("FAIL sq leaked act=%0d exp=0", leaked); end
  endtask

  task automatic test_wrap();
    EX_PACKET sent[9];
    EX_PACKET got[$];
    for (int i = 0; i < 9; i++) sent[i] = mk(i, 1);
    for (int i = 0; i < 13; i++) begin
      if (i < 9) step(sent[i], '0, 1'b0);
      else step('0, '0, 1'b0);
      if (act_out.valid === 1'b1) got.push_back(act_out);
      n_tests += 2;
      if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL wrap rdy c%0d act=%b exp=%b", i, act_rdy, exp_rdy); end
      if (act_out !== exp_out) begin n_fail++; $display("FAIL wrap out c%0d act=%h exp=%h", i, act_out, exp_out); end
    end
    n_tests++;
    if (got.size() != 9) begin
      n_fail++;
      $display("FAIL wrap count act=%0d exp=9", got.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_tests++;
        if (got[i] !== sent[i]) begin n_fail++; $display("FAIL wrap pkt%0d act=%h exp=%h", i, got[i], sent[i]); end
      end
    end
  endtask

  task automatic test_random();
    EX_PACKET a, b;
    bit sq;
    for (int i = 0; i < 300; i++) begin
      a = mk(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      b = mk(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      sq = ($urandom_range(0, 99) < 3);
      step(a, b, sq);
      n_tests += 3;
      if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand rdy c%0d act=%b exp=%b", i, act_rdy, exp_rdy); end
      if (act_out !== exp_out) begin n_fail++; $display("FAIL rand out c%0d act=%h exp=%h", i, act_out, exp_out); end
      if (act_occ !== 3'(exp_occ)) begin n_fail++; $display("FAIL rand occ c%0d act=%0d exp=%0d", i, act_occ, exp_occ); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_saturation();
    test_squash();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
